// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator.
// The multiply-accumulate stages import this package.
package acc_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultAccW  = 24;
  localparam int unsigned DefaultCntW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Input beat and output result handshakes of the product accumulator.
// The master side drives products and takes results; the slave side is the accumulator.
interface product_accumulator_if
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ACC_W  = DefaultAccW,
  parameter int unsigned CNT_W  = DefaultCntW
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CNT_W-1:0]  frame_len;
  logic [ACC_W-1:0]  out_sum;
  logic              out_valid;
  logic              out_ready;
  logic              out_overflow;

  modport master (
    output in_data,
    output in_valid,
    output frame_len,
    output out_ready,
    input  in_ready,
    input  out_sum,
    input  out_valid,
    input  out_overflow
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  frame_len,
    input  out_ready,
    output in_ready,
    output out_sum,
    output out_valid,
    output out_overflow
  );

endinterface

// File: rtl/product_accumulator_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on carry-out and flags the carry.
module sat_add
  import acc_pkg::*;
#(
  parameter int unsigned ACC_W = DefaultAccW
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] raw_sum;

  always_comb begin
    raw_sum = {1'b0, a_i} + {1'b0, b_i};
    carry_o = raw_sum[ACC_W];
    sum_o   = carry_o ? '1 : raw_sum[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmable number of consecutive products into a saturating accumulator
// and holds the frame sum on a valid/ready port until it is taken.
module product_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ACC_W  = DefaultAccW,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input logic                 clk,
  input logic                 rst_n,
  product_accumulator_if.slave bus
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             beat;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [CNT_W-1:0] cnt_inc;

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a_i     (acc_q),
    .b_i     (ACC_W'(bus.in_data)),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // in_ready depends on state only, never on in_valid or out_ready.
  assign bus.in_ready     = (state_q != HOLD);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = acc_q;
  assign bus.out_overflow = ovf_q;

  assign beat    = bus.in_valid && bus.in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          len_d   = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
          acc_d   = ACC_W'(bus.in_data);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (len_d == CNT_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_carry;
          if (cnt_inc == len_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
